// File: rtl/inst_mem_loadable_if.sv
// rtl/inst_mem_loadable_if.sv - fetch and program-load bus for the loadable instruction memory
interface inst_mem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              inst_fault;

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [IDX_W:0]    load_count;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_ready, inst, inst_valid, inst_fault, load_ready, load_done, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_ready, inst, inst_valid, inst_fault, load_ready, load_done, load_count
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// rtl/inst_mem_loadable.sv - loadable instruction memory with NOP fill, pipelined fetch and streaming load
module inst_mem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hFFFFFFFF
) (
  input logic                clk,
  input logic                rst_n,
  inst_mem_loadable_if.slave bus
);
  localparam int              IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]  COUNT_MAX  = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr, ptr_next;
  logic [IDX_W:0]    count_next;
  logic              done_next;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_fire;
  logic              fetch_ok;
  logic [IDX_W-1:0]  fetch_idx;

  // Fetch is only legal for word-aligned addresses that land inside the array.
  assign fetch_idx  = bus.fetch_addr[IDX_W+1:2];
  assign fetch_ok   = (bus.fetch_addr[1:0] == 2'b00) && ({1'b0, bus.fetch_addr} < ADDR_LIMIT);
  assign fetch_fire = bus.fetch_req && bus.fetch_ready;

  // Next-state, write port and handshake readiness, all decided by the current state.
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    count_next      = bus.load_count;
    done_next       = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = ptr;
    wr_data         = bus.load_data;
    bus.fetch_ready = 1'b0;
    bus.load_ready  = 1'b0;
    case (state)
      S_CLEAR: begin
        wr_en    = 1'b1;
        wr_data  = NOP_WORD;
        ptr_next = ptr + IDX_W'(1);
        if (ptr == LAST_IDX) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        bus.fetch_ready = 1'b1;
        if (bus.load_start) begin
          state_next = S_LOAD;
          ptr_next   = '0;
          count_next = '0;
        end
      end
      S_LOAD: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          wr_en    = 1'b1;
          ptr_next = ptr + IDX_W'(1);
          if (bus.load_count != COUNT_MAX) begin
            count_next = bus.load_count + (IDX_W + 1)'(1);
          end
          // Writing the top word ends the load even without load_last, so ptr never wraps onto word 0.
          if (bus.load_last || (ptr == LAST_IDX)) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_CLEAR;
      end
    endcase
  end

  // Control state; reset restarts the NOP fill and abandons any load in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_CLEAR;
      ptr            <= '0;
      bus.load_count <= '0;
      bus.load_done  <= 1'b0;
    end else begin
      state          <= state_next;
      ptr            <= ptr_next;
      bus.load_count <= count_next;
      bus.load_done  <= done_next;
    end
  end

  // Storage array; writes are suppressed while reset is asserted so an aborted beat never lands.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Fetch result register: one result per accepted request, inst holds when no fetch is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.inst       <= NOP_WORD;
      bus.inst_valid <= 1'b0;
      bus.inst_fault <= 1'b0;
    end else begin
      bus.inst_valid <= fetch_fire;
      bus.inst_fault <= fetch_fire && !fetch_ok;
      if (fetch_fire) begin
        bus.inst <= fetch_ok ? mem[fetch_idx] : NOP_WORD;
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_loadable.sv
// tb/tb_inst_mem_loadable.sv - self-checking bench for inst_mem_loadable
module tb_inst_mem_loadable;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_mem_loadable_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

  inst_mem_loadable #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] load_words [80];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
  endtask

  task automatic model_fill_nop;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
  endtask

  // Reference: a load writes the first min(n, DEPTH) words it is offered.
  task automatic model_load(input int n);
    for (int i = 0; i < n && i < DEPTH; i++) model_mem[i] = load_words[i];
  endtask

  // Reference fetch result: {fault, inst}.
  function automatic logic [32:0] exp_res(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) return {1'b1, NOP};
    return {1'b0, model_mem[int'(a >> 2)]};
  endfunction

  task automatic fetch1(input logic [31:0] a, output logic [31:0] d, output logic v, output logic f);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    tick();
    d = bus.inst;
    v = bus.inst_valid;
    f = bus.inst_fault;
    bus.fetch_req = 1'b0;
  endtask

  task automatic send_load(input int n, input bit use_last, output int ready_beats, output int done_pulses);
    ready_beats = 0;
    done_pulses = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = load_words[i];
      bus.load_last  = use_last && (i == n - 1);
      if (bus.load_ready) ready_beats++;
      tick();
      if (bus.load_done) done_pulses++;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    tick();
    if (bus.load_done) done_pulses++;
  endtask

  task automatic test_reset;
    int cycles;
    logic [31:0] d;
    logic v, f;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++; if (bus.inst !== NOP) $display("FAIL reset_inst got %h want %h", bus.inst, NOP); else n_pass++;
    n_total++; if ({bus.inst_valid, bus.inst_fault, bus.load_done} !== 3'b000)
      $display("FAIL reset_flags got valid/fault/done=%b want 000", {bus.inst_valid, bus.inst_fault, bus.load_done}); else n_pass++;
    n_total++; if (bus.load_count !== 7'd0) $display("FAIL reset_count got %0d want 0", bus.load_count); else n_pass++;
    n_total++; if ({bus.fetch_ready, bus.load_ready} !== 2'b00)
      $display("FAIL reset_ready got fetch/load=%b want 00", {bus.fetch_ready, bus.load_ready}); else n_pass++;
    rst_n = 1'b1;
    cycles = 0;
    while (!bus.fetch_ready && cycles < 200) begin
      tick();
      cycles++;
    end
    n_total++; if (cycles !== DEPTH) $display("FAIL clear_cycles got %0d want %0d", cycles, DEPTH); else n_pass++;
    model_fill_nop();
    fetch1(32'h0, d, v, f);
    n_total++; if ({f, v, d} !== {1'b0, 1'b1, NOP})
      $display("FAIL fetch_after_clear got f=%b v=%b inst=%h want f=0 v=1 inst=%h", f, v, d, NOP); else n_pass++;
  endtask

  task automatic test_load_basic;
    int rb, dp;
    logic [31:0] d;
    logic v, f;
    logic [32:0] e;
    logic [31:0] addrs [2];
    load_words[0] = 32'h20230000;
    load_words[1] = 32'h14210001;
    load_words[2] = 32'h24230000;
    send_load(3, 1'b1, rb, dp);
    model_load(3);
    n_total++; if (rb !== 3) $display("FAIL load3_ready_beats got %0d want 3", rb); else n_pass++;
    n_total++; if (dp !== 1) $display("FAIL load3_done_pulses got %0d want 1", dp); else n_pass++;
    n_total++; if (bus.load_count !== 7'd3) $display("FAIL load3_count got %0d want 3", bus.load_count); else n_pass++;
    addrs[0] = 32'h4;
    addrs[1] = 32'hC;
    for (int i = 0; i < 2; i++) begin
      fetch1(addrs[i], d, v, f);
      e = exp_res(addrs[i]);
      n_total++; if ({f, v, d} !== {e[32], 1'b1, e[31:0]})
        $display("FAIL load3_fetch_%h got f=%b v=%b inst=%h want f=%b v=1 inst=%h", addrs[i], f, v, d, e[32], e[31:0]); else n_pass++;
    end
  endtask

  task automatic test_fault;
    logic [31:0] d;
    logic v, f;
    logic [32:0] e;
    logic [31:0] addrs [5];
    addrs[0] = 32'h100; addrs[1] = 32'h6; addrs[2] = 32'h8; addrs[3] = 32'hFC; addrs[4] = 32'hFFFF_FFFC;
    for (int i = 0; i < 5; i++) begin
      fetch1(addrs[i], d, v, f);
      e = exp_res(addrs[i]);
      n_total++; if ({f, v, d} !== {e[32], 1'b1, e[31:0]})
        $display("FAIL fault_fetch_%h got f=%b v=%b inst=%h want f=%b v=1 inst=%h", addrs[i], f, v, d, e[32], e[31:0]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e;
    logic [31:0] last_inst;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'(4 * i);
      tick();
      e = exp_res(32'(4 * i));
      n_total++; if ({bus.inst_fault, bus.inst_valid, bus.inst} !== {e[32], 1'b1, e[31:0]})
        $display("FAIL b2b_%0d got f=%b v=%b inst=%h want f=%b v=1 inst=%h", i, bus.inst_fault, bus.inst_valid, bus.inst, e[32], e[31:0]); else n_pass++;
      last_inst = e[31:0];
    end
    bus.fetch_req = 1'b0;
    tick();
    n_total++; if ({bus.inst_valid, bus.inst_fault, bus.inst} !== {2'b00, last_inst})
      $display("FAIL b2b_hold got v=%b f=%b inst=%h want v=0 f=0 inst=%h", bus.inst_valid, bus.inst_fault, bus.inst, last_inst); else n_pass++;
  endtask

  task automatic test_fetch_during_load;
    logic [32:0] e;
    logic [31:0] d;
    logic v, f;
    e = exp_res(32'h4);
    bus.load_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h4;
    tick();
    bus.load_start = 1'b0;
    n_total++; if ({bus.inst_valid, bus.inst} !== {1'b1, e[31:0]})
      $display("FAIL start_and_fetch got v=%b inst=%h want v=1 inst=%h", bus.inst_valid, bus.inst, e[31:0]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if ({bus.inst_valid, bus.fetch_ready, bus.load_ready} !== 3'b001)
        $display("FAIL fetch_in_load_%0d got valid/fetch_ready/load_ready=%b want 001", i,
                 {bus.inst_valid, bus.fetch_ready, bus.load_ready}); else n_pass++;
    end
    bus.fetch_req  = 1'b0;
    load_words[0]  = $urandom;
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b1;
    bus.load_data  = load_words[0];
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    model_mem[0]   = load_words[0];
    n_total++; if ({bus.load_done, bus.load_count} !== {1'b1, 7'd1})
      $display("FAIL single_beat_load got done=%b count=%0d want done=1 count=1", bus.load_done, bus.load_count); else n_pass++;
    fetch1(32'h0, d, v, f);
    n_total++; if ({f, v, d} !== {1'b0, 1'b1, model_mem[0]})
      $display("FAIL single_beat_fetch got f=%b v=%b inst=%h want f=0 v=1 inst=%h", f, v, d, model_mem[0]); else n_pass++;
  endtask

  task automatic test_full_load;
    int rb, dp;
    logic [32:0] e;
    for (int i = 0; i < 65; i++) load_words[i] = $urandom;
    send_load(65, 1'b0, rb, dp);
    model_load(65);
    n_total++; if (rb !== DEPTH) $display("FAIL full_ready_beats got %0d want %0d", rb, DEPTH); else n_pass++;
    n_total++; if (dp !== 1) $display("FAIL full_done_pulses got %0d want 1", dp); else n_pass++;
    n_total++; if (bus.load_count !== 7'd64) $display("FAIL full_count got %0d want 64", bus.load_count); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'(4 * i);
      tick();
      e = exp_res(32'(4 * i));
      n_total++; if ({bus.inst_fault, bus.inst_valid, bus.inst} !== {e[32], 1'b1, e[31:0]})
        $display("FAIL full_word_%0d got f=%b v=%b inst=%h want inst=%h", i, bus.inst_fault, bus.inst_valid, bus.inst, e[31:0]); else n_pass++;
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_random;
    int rb, dp, n, want_w;
    bit use_last, req;
    logic [31:0] a, last_inst;
    logic [32:0] e;
    last_inst = bus.inst;
    for (int r = 0; r < 6; r++) begin
      use_last = ($urandom_range(0, 3) != 0);
      n = use_last ? int'($urandom_range(1, 64)) : int'($urandom_range(64, 66));
      for (int i = 0; i < n; i++) load_words[i] = $urandom;
      send_load(n, use_last, rb, dp);
      model_load(n);
      want_w = (n < DEPTH) ? n : DEPTH;
      n_total++; if ({rb, dp} !== {want_w, 1})
        $display("FAIL rand_load_%0d got beats=%0d done=%0d want beats=%0d done=1", r, rb, dp, want_w); else n_pass++;
      n_total++; if (bus.load_count !== 7'(want_w))
        $display("FAIL rand_count_%0d got %0d want %0d", r, bus.load_count, want_w); else n_pass++;
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0: a = {$urandom} & 32'hFFFF_FFFC;
          1: a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
          default: a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        endcase
        req = ($urandom_range(0, 4) != 0);
        bus.fetch_req  = req;
        bus.fetch_addr = a;
        tick();
        if (req) begin
          e = exp_res(a);
          last_inst = e[31:0];
        end else begin
          e = {1'b0, last_inst};
        end
        n_total++; if ({bus.inst_valid, bus.inst_fault, bus.inst} !== {req, e[32], e[31:0]})
          $display("FAIL rand_fetch_%0d_%0d addr=%h got v=%b f=%b inst=%h want v=%b f=%b inst=%h", r, k, a,
                   bus.inst_valid, bus.inst_fault, bus.inst, req, e[32], e[31:0]); else n_pass++;
      end
      bus.fetch_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_load;
    int cycles;
    logic [32:0] e;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    rst_n = 1'b0;
    bus.load_data = 32'h5A5A_5A5A;
    tick();
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    model_fill_nop();
    n_total++; if ({bus.load_count, bus.load_ready} !== {7'd0, 1'b0})
      $display("FAIL midreset_state got count=%0d load_ready=%b want 0 0", bus.load_count, bus.load_ready); else n_pass++;
    cycles = 0;
    while (!bus.fetch_ready && cycles < 200) begin
      tick();
      cycles++;
    end
    n_total++; if (cycles !== DEPTH) $display("FAIL midreset_clear_cycles got %0d want %0d", cycles, DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'(4 * i);
      tick();
      e = exp_res(32'(4 * i));
      n_total++; if ({bus.inst_fault, bus.inst_valid, bus.inst} !== {e[32], 1'b1, e[31:0]})
        $display("FAIL midreset_word_%0d got f=%b v=%b inst=%h want inst=%h", i, bus.inst_fault, bus.inst_valid, bus.inst, e[31:0]); else n_pass++;
    end
    bus.fetch_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_fault();
    test_fetch_during_load();
    test_full_load();
    test_random();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
